// File: rtl/img_gray_conv_if.sv
// Pixel stream bundle for img_gray_conv: RGB input side and grey output side.
// Ports: data/valid/sof/eol/ready_i toward the converter, data/valid/sof/eol/ready_o back.
interface img_gray_conv_if #(
    parameter int CW = 8
);
    logic [3*CW-1:0] data_i;
    logic            valid_i;
    logic            sof_i;
    logic            eol_i;
    logic            ready_o;

    logic [3*CW-1:0] data_o;
    logic            valid_o;
    logic            sof_o;
    logic            eol_o;
    logic            ready_i;

    modport master (
        output data_i, valid_i, sof_i, eol_i, ready_i,
        input  ready_o, data_o, valid_o, sof_o, eol_o
    );

    modport slave (
        input  data_i, valid_i, sof_i, eol_i, ready_i,
        output ready_o, data_o, valid_o, sof_o, eol_o
    );
endinterface

// File: rtl/img_gray_conv.sv
// RGB to greyscale converter: 3-stage pipeline (products/max, sum, round/sat/threshold).
// Ports: clk, reset_n (async low), px stream bundle, mode_i/bin_en_i/thresh_i config, frame_cnt_o.
module img_gray_conv #(
    parameter int CW   = 8,
    parameter int MODE = 1,
    parameter int FRAC = 10,
    parameter int W_R  = 306,
    parameter int W_G  = 601,
    parameter int W_B  = 117
) (
    input  logic          clk,
    input  logic          reset_n,
    img_gray_conv_if.slave px,
    input  logic [1:0]    mode_i,
    input  logic          bin_en_i,
    input  logic [CW-1:0] thresh_i,
    output logic [15:0]   frame_cnt_o
);
    localparam int CFW   = FRAC + 1;
    localparam int PW    = CW + CFW;
    localparam int SW    = CW + FRAC + 3;
    localparam int K_AVG = ((1 << FRAC) + 1) / 3;

    localparam logic [CFW-1:0] C_R   = CFW'(W_R);
    localparam logic [CFW-1:0] C_G   = CFW'(W_G);
    localparam logic [CFW-1:0] C_B   = CFW'(W_B);
    localparam logic [CFW-1:0] C_K   = CFW'(K_AVG);
    localparam logic [SW-1:0]  HALF  = SW'(1) << (FRAC - 1);
    localparam logic [CW-1:0]  Y_MAX = '1;

    logic en;
    logic acc;

    assign en         = px.ready_i || !px.valid_o;
    assign acc        = px.valid_i && en;
    assign px.ready_o = en;

    // Run-time configuration, captured on each accepted start-of-frame
    logic [1:0]    mode_q;
    logic          bin_q;
    logic [CW-1:0] thr_q;

    // A sof pixel already uses the configuration it carries
    logic [1:0]    mode_e;
    logic          bin_e;
    logic [CW-1:0] thr_e;

    assign mode_e = px.sof_i ? mode_i   : mode_q;
    assign bin_e  = px.sof_i ? bin_en_i : bin_q;
    assign thr_e  = px.sof_i ? thresh_i : thr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 2'(MODE);
            bin_q  <= 1'b0;
            thr_q  <= '0;
        end else if (acc && px.sof_i) begin
            mode_q <= mode_i;
            bin_q  <= bin_en_i;
            thr_q  <= thresh_i;
        end
    end

    logic [CW-1:0]  r_in, g_in, b_in;
    logic [CFW-1:0] cr, cg, cb;
    logic [CW-1:0]  mx;
    logic           is_max;

    assign r_in = px.data_i[3*CW-1:2*CW];
    assign g_in = px.data_i[2*CW-1:CW];
    assign b_in = px.data_i[CW-1:0];

    always_comb begin
        cr     = C_R;
        cg     = C_G;
        cb     = C_B;
        is_max = 1'b0;
        unique case (1'b1)
            (mode_e == 2'd0): begin
                cr = C_K;
                cg = C_K;
                cb = C_K;
            end
            (mode_e == 2'd2): is_max = 1'b1;
            default: ;
        endcase
        mx = r_in;
        if (g_in > mx) mx = g_in;
        if (b_in > mx) mx = b_in;
    end

    // Stage 1: per-channel products and channel maximum
    logic          v1, sf1, el1, ms1, bin1;
    logic [CW-1:0] mx1, thr1;
    logic [PW-1:0] pr1, pg1, pb1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            sf1  <= 1'b0;
            el1  <= 1'b0;
            ms1  <= 1'b0;
            bin1 <= 1'b0;
            mx1  <= '0;
            thr1 <= '0;
            pr1  <= '0;
            pg1  <= '0;
            pb1  <= '0;
        end else if (en) begin
            v1   <= px.valid_i;
            sf1  <= px.valid_i && px.sof_i;
            el1  <= px.valid_i && px.eol_i;
            ms1  <= is_max;
            bin1 <= bin_e;
            mx1  <= mx;
            thr1 <= thr_e;
            pr1  <= PW'(r_in) * PW'(cr);
            pg1  <= PW'(g_in) * PW'(cg);
            pb1  <= PW'(b_in) * PW'(cb);
        end
    end

    // Stage 2: rounded sum of products
    logic          v2, sf2, el2, ms2, bin2;
    logic [CW-1:0] mx2, thr2;
    logic [SW-1:0] sum2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2   <= 1'b0;
            sf2  <= 1'b0;
            el2  <= 1'b0;
            ms2  <= 1'b0;
            bin2 <= 1'b0;
            mx2  <= '0;
            thr2 <= '0;
            sum2 <= '0;
        end else if (en) begin
            v2   <= v1;
            sf2  <= sf1;
            el2  <= el1;
            ms2  <= ms1;
            bin2 <= bin1;
            mx2  <= mx1;
            thr2 <= thr1;
            sum2 <= SW'(pr1) + SW'(pg1) + SW'(pb1) + HALF;
        end
    end

    // Stage 3: scale down, saturate, optional binarisation
    logic [SW-1:0] ysh;
    logic [CW-1:0] ysat, ysel, yout;

    always_comb begin
        ysh  = sum2 >> FRAC;
        ysat = (ysh > SW'(Y_MAX)) ? Y_MAX : ysh[CW-1:0];
        ysel = ms2 ? mx2 : ysat;
        yout = ysel;
        if (bin2) yout = (ysel >= thr2) ? Y_MAX : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px.valid_o <= 1'b0;
            px.sof_o   <= 1'b0;
            px.eol_o   <= 1'b0;
            px.data_o  <= '0;
        end else if (en) begin
            px.valid_o <= v2;
            px.sof_o   <= sf2;
            px.eol_o   <= el2;
            px.data_o  <= {3{yout}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_o <= '0;
        end else if (px.valid_o && px.ready_i && px.sof_o) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
endmodule
